// File: rtl/r_mem_reader_pkg.sv
// Shared types and helpers for the r_mem streaming reader.
package r_mem_reader_pkg;

  // r_mem has an address register plus an output register in front of q.
  localparam int READ_LATENCY = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } reader_state_e;

  // A new read may only be issued while every word already promised to the
  // output buffer (still in the memory pipeline or already stored) leaves a
  // free slot for it.
  function automatic logic hasCredit(input int inFlight, input int occupancy,
                                     input int depth);
    return (inFlight + occupancy) < depth;
  endfunction

endpackage

// File: rtl/r_mem_reader_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the reader's output buffer.
module sync_fifo
  import r_mem_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = store_q[rdPtr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Storage array; contents are don't-care until counted as valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      store_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/r_mem_reader.sv
// Streams every word of r_mem, address 0 upward, onto a valid/ready output.
// Reads are tracked through the two-cycle memory pipeline by a valid/last tag
// shift register and land in a small FIFO; issue is throttled by credit so the
// FIFO can never overflow whatever the consumer does.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 16
`endif

module r_mem_reader
  import r_mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int TOTAL_ADDR = `TOTAL_ADDR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_ADDR - 1);

  reader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  tag1Valid_q;
  logic                  tag1Last_q;
  logic                  tag2Valid_q;
  logic                  tag2Last_q;

  logic [1:0]            inFlight;
  logic [CW-1:0]         fifoCount;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic [DATA_WIDTH:0]   fifoHead;
  logic                  fifoPush;
  logic                  fifoPop;
  logic                  creditOk;
  logic                  isLast;
  logic                  issueNow;

  assign inFlight = {1'b0, tag1Valid_q} + {1'b0, tag2Valid_q};
  assign creditOk = hasCredit(int'(inFlight), int'(fifoCount), FIFO_DEPTH);
  assign isLast   = (addr_q == LAST_ADDR);

  // The address already on mem_address is the one being issued this cycle,
  // so a start in IDLE issues address 0 immediately.
  assign issueNow = ((state_q == S_IDLE) && start) ||
                    ((state_q == S_FETCH) && creditOk);

  assign fifoPop  = out_valid && out_ready;
  assign fifoPush = tag2Valid_q && (!fifoFull || fifoPop);

  assign mem_address = addr_q;
  assign out_valid   = !fifoEmpty;
  assign out_data    = fifoHead[DATA_WIDTH-1:0];
  assign out_last    = fifoHead[DATA_WIDTH];
  assign busy        = busy_q;
  assign done        = done_q;

  // Run control, address issue and read tagging in one registered FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag1Valid_q <= 1'b0;
      tag1Last_q  <= 1'b0;
      tag2Valid_q <= 1'b0;
      tag2Last_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      tag2Valid_q <= tag1Valid_q;
      tag2Last_q  <= tag1Last_q;
      tag1Valid_q <= issueNow;
      tag1Last_q  <= issueNow && isLast;
      if (issueNow && !isLast) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= isLast ? S_DRAIN : S_FETCH;
          end
        end
        S_FETCH: begin
          if (issueNow && isLast) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifoEmpty && !tag1Valid_q && !tag2Valid_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          addr_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifoPush),
    .data_i  ({tag2Last_q, mem_q}),
    .pop_i   (fifoPop),
    .data_o  (fifoHead),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull),
    .count_o (fifoCount)
  );

endmodule

// File: tb/tb_r_mem_reader.sv
// Bench for r_mem_reader: a two-cycle r_mem model feeds the reader while a
// scoreboard checks order, last flag, handshake stability, timing and done.
module tb_r_mem_reader;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int TOTAL = 16;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] memModel [TOTAL];
  logic [AW-1:0] memAddrReg = '0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   gotCount = 0;
  int   doneCount = 0;
  int   resetAt = -1;
  bit   timed = 1'b0;
  bit   holdPending = 1'b0;
  logic [DW-1:0] holdData = '0;
  logic holdLast = 1'b0;

  r_mem_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TOTAL_ADDR (TOTAL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mem_address (mem_address),
    .mem_q       (mem_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // r_mem model: registered address, then registered q.
  always @(posedge clock) begin
    memAddrReg <= mem_address;
    mem_q      <= memModel[memAddrReg];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard for one cycle: outputs are sampled mid-cycle, after the inputs
  // for this cycle have been applied.
  task automatic scoreCycle();
    if (holdPending) begin
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdData", 32'(out_data), 32'(holdData));
      checkOutput("holdLast", 32'(out_last), 32'(holdLast));
    end
    holdPending = out_valid && !out_ready;
    holdData    = out_data;
    holdLast    = out_last;

    if (timed && cyc == 0) checkOutput("busyBeforeRun", 32'(busy), 32'd0);
    if (timed && cyc == 1) begin
      checkOutput("busyRise", 32'(busy), 32'd1);
      checkOutput("addrCycle1", 32'(mem_address), 32'd1);
    end

    if (resetAt >= 0 && cyc > resetAt) begin
      checkOutput("validAfterRst", 32'(out_valid), 32'd0);
      checkOutput("busyAfterRst", 32'(busy), 32'd0);
      if (cyc == resetAt + 1) checkOutput("addrAfterRst", 32'(mem_address), 32'd0);
    end

    if (out_valid && out_ready) begin
      if (gotCount < TOTAL) begin
        checkOutput("wordData", 32'(out_data), 32'(memModel[gotCount]));
        checkOutput("lastFlag", 32'(out_last), 32'(gotCount == TOTAL - 1));
        if (timed) checkOutput("wordCycle", 32'(cyc), 32'(3 + gotCount));
      end else begin
        checkOutput("extraWord", 32'(gotCount), 32'(TOTAL - 1));
      end
      gotCount++;
    end

    if (done) begin
      doneCount++;
      checkOutput("doneWordCount", 32'(gotCount), 32'(TOTAL));
      if (timed) checkOutput("doneCycle", 32'(cyc), 32'd20);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rdy, input logic rs);
    @(negedge clock);
    start     = st;
    out_ready = rdy;
    reset     = rs;
    scoreCycle();
    cyc++;
  endtask

  // One run: start at cycle 0; readyMode 0 = always ready, 1 = stall cycles
  // 4..13, 2 = random 50%. restartAt/rstAt < 0 disable those events.
  task automatic runOnce(input bit isTimed, input int readyMode, input int restartAt,
                         input int rstAt, input int maxCycles);
    int postDone;
    timed       = isTimed;
    resetAt     = rstAt;
    cyc         = 0;
    gotCount    = 0;
    doneCount   = 0;
    holdPending = 1'b0;
    postDone    = 0;
    for (int k = 0; k < maxCycles; k++) begin
      logic st;
      logic rdy;
      logic rs;
      st = (cyc == 0) || (cyc == restartAt);
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = !(cyc >= 4 && cyc < 14);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rs = (cyc == rstAt);
      applyStimulus(st, rdy, rs);
      if (doneCount > 0) begin
        postDone++;
        if (postDone > 3) break;
      end
    end
    if (rstAt < 0) begin
      checkOutput("wordsDelivered", 32'(gotCount), 32'(TOTAL));
      checkOutput("donePulses", 32'(doneCount), 32'd1);
    end else begin
      checkOutput("wordsBeforeRst", 32'(gotCount), 32'((rstAt >= 3) ? rstAt - 2 : 0));
      checkOutput("donePulses", 32'(doneCount), 32'd0);
    end
    timed   = 1'b0;
    resetAt = -1;
  endtask

  initial begin
    for (int i = 0; i < TOTAL; i++) memModel[i] = DW'(i + 1);

    // Reset state.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstLast", 32'(out_last), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstAddr", 32'(mem_address), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] full-rate stream with exact timing");
    runOnce(1'b1, 0, -1, -1, 100);

    $display("[TB] consumer stall cycles 4..13");
    runOnce(1'b0, 1, -1, -1, 100);

    $display("[TB] random ready, random memory contents");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < TOTAL; i++) memModel[i] = DW'($urandom);
      runOnce(1'b0, 2, -1, -1, 300);
    end
    for (int i = 0; i < TOTAL; i++) memModel[i] = DW'(i + 1);

    $display("[TB] start pulsed again mid-run");
    runOnce(1'b1, 0, 5, -1, 100);

    $display("[TB] reset at cycle 8, then fresh run");
    runOnce(1'b0, 0, -1, 8, 20);
    runOnce(1'b1, 0, -1, -1, 100);

    $display("[TB] reset together with start");
    runOnce(1'b0, 0, -1, 0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
